// File: rtl/effect_energy_ctrl.sv
// rtl/effect_energy_ctrl.sv - player energy counter with power-up and curse effect timers
// Optional idle-second energy regeneration is enabled by defining ENERGY_REGEN_EN.
module effect_energy_ctrl #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned POWER_UP_SEC = 5,
    parameter int unsigned CURSE_SEC    = 8,
    parameter int unsigned ENERGY_INIT  = 10,
    parameter int unsigned ENERGY_MAX   = 2000,
    parameter int unsigned PICKUP_GAIN  = 5
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        en,
    input  logic        move_step,
    input  logic        pickup_energy,
    input  logic        pickup_power,
    input  logic        pickup_curse,
    output logic        power_up_active,
    output logic        curse_active,
    output logic [10:0] energy,
    output logic [3:0]  power_left,
    output logic [3:0]  curse_left,
    output logic        exhausted
);

    localparam logic [31:0] TICK_LAST = 32'(CLK_HZ - 1);
    localparam logic [3:0]  P_DUR     = 4'(POWER_UP_SEC);
    localparam logic [3:0]  C_DUR     = 4'(CURSE_SEC);
    localparam logic [11:0] E_MAX     = 12'(ENERGY_MAX);
    localparam logic [11:0] E_GAIN    = 12'(PICKUP_GAIN);

    typedef enum logic {IDLE, ACTIVE} fx_state_t;

    fx_state_t   p_state, p_state_next;
    fx_state_t   c_state, c_state_next;
    logic [31:0] tick_cnt;
    logic        tick;
    logic        moved;
    logic        drain;
    logic        regen;
    logic [11:0] energy_sum;
    logic [11:0] energy_clamped;
    logic [10:0] energy_next;
    logic [3:0]  power_left_next;
    logic [3:0]  curse_left_next;

    assign tick  = en && (tick_cnt == TICK_LAST);
    assign drain = tick && moved && !power_up_active;
`ifdef ENERGY_REGEN_EN
    assign regen = tick && !moved;
`else
    assign regen = 1'b0;
`endif

    // Gain and regen are added before drain so that drain at zero floors cleanly.
    always_comb begin
        energy_sum     = {1'b0, energy} + (pickup_energy ? E_GAIN : 12'd0) + {11'd0, regen};
        energy_clamped = 12'd0;
        if (energy_sum >= {11'd0, drain})
            energy_clamped = energy_sum - {11'd0, drain};
        if (energy_clamped > E_MAX)
            energy_clamped = E_MAX;
        energy_next = energy_clamped[10:0];
    end

    always_comb begin
        p_state_next    = p_state;
        power_left_next = power_left;
        case (p_state)
            IDLE: begin
                if (pickup_power) begin
                    p_state_next    = ACTIVE;
                    power_left_next = P_DUR;
                end
            end
            ACTIVE: begin
                if (pickup_power) begin
                    power_left_next = P_DUR;
                end else if (tick) begin
                    if (power_left == 4'd1) begin
                        p_state_next    = IDLE;
                        power_left_next = 4'd0;
                    end else begin
                        power_left_next = power_left - 4'd1;
                    end
                end
            end
            default: p_state_next = IDLE;
        endcase
    end

    // A power pickup both blocks a new curse and cancels a running one.
    always_comb begin
        c_state_next    = c_state;
        curse_left_next = curse_left;
        case (c_state)
            IDLE: begin
                if (pickup_curse && !power_up_active && !pickup_power) begin
                    c_state_next    = ACTIVE;
                    curse_left_next = C_DUR;
                end
            end
            ACTIVE: begin
                if (pickup_power) begin
                    c_state_next    = IDLE;
                    curse_left_next = 4'd0;
                end else if (pickup_curse) begin
                    curse_left_next = C_DUR;
                end else if (tick) begin
                    if (curse_left == 4'd1) begin
                        c_state_next    = IDLE;
                        curse_left_next = 4'd0;
                    end else begin
                        curse_left_next = curse_left - 4'd1;
                    end
                end
            end
            default: c_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            tick_cnt        <= 32'd0;
            moved           <= 1'b0;
            energy          <= 11'(ENERGY_INIT);
            exhausted       <= (ENERGY_INIT == 0);
            p_state         <= IDLE;
            c_state         <= IDLE;
            power_left      <= 4'd0;
            curse_left      <= 4'd0;
            power_up_active <= 1'b0;
            curse_active    <= 1'b0;
        end else if (en) begin
            tick_cnt        <= tick ? 32'd0 : tick_cnt + 32'd1;
            moved           <= move_step || (moved && !tick);
            energy          <= energy_next;
            exhausted       <= (energy_next == 11'd0);
            p_state         <= p_state_next;
            c_state         <= c_state_next;
            power_left      <= power_left_next;
            curse_left      <= curse_left_next;
            power_up_active <= (p_state_next == ACTIVE);
            curse_active    <= (c_state_next == ACTIVE);
        end
    end

endmodule

// File: doc/effect_energy_ctrl.md
Name: effect_energy_ctrl

Overview:
- Upstream of the velocity-clock generator. Owns the player's energy counter and the power-up and curse effect timers.
- Produces `power_up_active`, `curse_active` and `energy[10:0]`, which the speed stage consumes directly.
- Driven by pickup pulses from the collision logic and by a movement-step pulse from the movement controller.

Parameters:
- `CLK_HZ`, 100_000_000, sysclk cycles per 1 s tick; benches use 10.
- `POWER_UP_SEC`, 5, power-up duration in ticks.
- `CURSE_SEC`, 8, curse duration in ticks.
- `ENERGY_INIT`, 10, energy value after reset.
- `ENERGY_MAX`, 2000, energy saturation ceiling; must be ≤ 2047.
- `PICKUP_GAIN`, 5, energy added per energy pickup.

Ports:
- `sysclk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `en` in 1: game-running enable; low freezes all state.
- `move_step` in 1: one-cycle pulse per player movement step.
- `pickup_energy` in 1: one-cycle pulse, energy item collected.
- `pickup_power` in 1: one-cycle pulse, power-up item collected.
- `pickup_curse` in 1: one-cycle pulse, curse item touched.
- `power_up_active` out 1: power-up effect in force.
- `curse_active` out 1: curse effect in force.
- `energy` out 11: current energy, unsigned.
- `power_left` out 4: remaining power-up ticks; 0 when inactive.
- `curse_left` out 4: remaining curse ticks; 0 when inactive.
- `exhausted` out 1: high when energy == 0.

Behaviour:
- Clock and reset: clock sysclk; reset is synchronous, active-high.
- Reset values: tick counter 0, `moved` flag 0, `energy` = ENERGY_INIT, both FSMs IDLE, `power_left` = `curse_left` = 0, `power_up_active` = `curse_active` = 0, `exhausted` = (ENERGY_INIT == 0).
  - Reset mid-effect aborts the effect immediately, on the next edge.
- `en` low: tick counter, timers, energy and `moved` flag all hold; pickups and `move_step` are ignored. Outputs hold.
- Tick generator: 32-bit counter 0..CLK_HZ-1 while `en`.
  - Internal `tick` is high for one cycle when count == CLK_HZ-1; the counter wraps to 0 in the same cycle.
- Movement latch: `moved` is set by `move_step` and cleared on `tick`.
  - When `move_step` and `tick` coincide, `moved` ends at 1; that step counts toward the next second.
- Energy update, one registered update per cycle: `energy_next` = `energy` + gain − drain.
  - gain = PICKUP_GAIN if `pickup_energy`.
  - drain = 1 if (`tick` && `moved` && !`power_up_active`).
  - Compute in 12 bits, clamp to [0, ENERGY_MAX].
  - Simultaneous pickup and drain yields the net value in one cycle.
- `exhausted` is registered and equals (`energy_next` == 0).
- Power-up FSM, states IDLE / ACTIVE:
  - IDLE → ACTIVE on `pickup_power`; load `power_left` = POWER_UP_SEC.
  - In ACTIVE, `pickup_power` reloads POWER_UP_SEC (restart, no accumulation).
  - In ACTIVE, `tick` decrements `power_left`. On the tick where `power_left` == 1: → IDLE, `power_left` = 0.
  - Pickup and tick in the same cycle: the reload wins.
  - `power_up_active` = (state == ACTIVE), registered and updated on the same edge as the state.
- Curse FSM, states IDLE / ACTIVE:
  - IDLE → ACTIVE on `pickup_curse`, only if the power-up is not active and `pickup_power` is not asserted this cycle.
  - A curse pickup during a power-up is discarded (immunity).
  - `pickup_power` while the curse is ACTIVE cancels it: → IDLE, `curse_left` = 0, on the same edge the power-up starts.
  - `pickup_curse` in ACTIVE reloads CURSE_SEC.
  - Tick decrement and expiry follow the same rules as the power-up FSM.
- Latency: pickup pulse at edge N; outputs reflect it after edge N, i.e. visible during cycle N+1.
- Widths: `power_left` and `curse_left` are 4 bits; durations > 15 are illegal.

Optional Feature:
- Macro: `ENERGY_REGEN_EN`.
- When defined: on `tick` with `moved` == 0, energy gains +1, saturating at ENERGY_MAX. This stacks with `pickup_energy` in the same cycle, clamped once.
- When undefined: energy changes only by pickup gain and movement drain; idle seconds leave energy unchanged.

Test Plan:
- Reset with ENERGY_INIT=10 → energy=10, both active flags 0, `power_left`=`curse_left`=0, `exhausted`=0; counters frozen while `en`=0.
- CLK_HZ=10, one `move_step` per 10-cycle window for 3 windows → energy 10→9→8→7, one decrement per tick. `pickup_energy` coincident with a draining tick → energy 7+5−1=11.
- `pickup_power`, then 5 ticks with movement → `power_up_active` high for exactly 5 ticks, `power_left` 5,4,3,2,1,0, energy unchanged. A repeat pickup at `power_left`=2 → reloads to 5.
- `pickup_curse` during power-up → `curse_active` stays 0. Curse while idle → `curse_active`=1, `curse_left`=8. `pickup_power` at `curse_left`=4 → curse cleared and power-up active on the same edge. Simultaneous power+curse pickup → only power-up starts.
- Energy=1 with move then tick → energy 0, `exhausted`=1, further drains hold at 0. Energy at ENERGY_MAX with `pickup_energy` → stays at ENERGY_MAX. Reset asserted mid-curse → all outputs return to reset values on the next edge.
- With `ENERGY_REGEN_EN`: 3 idle ticks from 7 → 8,9,10. Without the macro: energy stays 7.
